// File: rtl/snn_ctrl.sv
// Spiking-network front-end controller: unpacks serial image bytes into the
// 784x1 input-unit RAM, starts the inference core and sends the ASCII result.
module snn_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       ram_we,
   output logic [9:0] ram_addr,
   output logic       ram_d,
   input  logic [9:0] core_addr,
   output logic       core_start,
   input  logic       core_done,
   input  logic [3:0] core_digit,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic [3:0] digit_out,
   output logic       busy
);

   typedef enum logic [2:0] {
      LOAD,
      WRITE,
      START,
      WAIT,
      TX,
      TX_WAIT
   } state_t;

   state_t     state;
   state_t     state_d;
   logic [9:0] pix_cnt;
   logic [7:0] shift;
   logic       last_bit;
   logic       last_pixel;

   // Bytes always land on 8-pixel boundaries, so the low counter bits index the bit.
   assign last_bit   = (pix_cnt[2:0] == 3'd7);
   assign last_pixel = (pix_cnt == 10'd783);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d    = state;
      ram_we     = 1'b0;
      core_start = 1'b0;
      tx_start   = 1'b0;
      busy       = 1'b1;
      case (state)
         LOAD: begin
            busy = 1'b0;
            if (rx_rdy) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            ram_we = 1'b1;
            if (last_bit) begin
               state_d = last_pixel ? START : LOAD;
            end
         end
         START: begin
            core_start = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               state_d = TX;
            end
         end
         TX: begin
            tx_start = 1'b1;
            state_d  = TX_WAIT;
         end
         TX_WAIT: begin
            if (tx_done) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // The core owns the RAM address once the image is complete.
   assign ram_addr = ((state == LOAD) || (state == WRITE)) ? pix_cnt : core_addr;
   assign ram_d    = (state == WRITE) ? shift[0] : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt   <= 10'd0;
         shift     <= 8'd0;
         digit_out <= 4'd0;
         tx_data   <= 8'd0;
      end else begin
         case (state)
            LOAD: begin
               if (rx_rdy) begin
                  shift <= rx_data;
               end
            end
            WRITE: begin
               shift   <= {1'b0, shift[7:1]};
               pix_cnt <= (last_bit && last_pixel) ? 10'd0 : pix_cnt + 10'd1;
            end
            WAIT: begin
               // tx_data is formed here so it is already valid during the TX cycle.
               if (core_done) begin
                  digit_out <= core_digit;
                  tx_data   <= (core_digit <= 4'd9) ? (8'h30 + {4'h0, core_digit}) : 8'h3F;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snn_ctrl.sv
// Self-checking bench for snn_ctrl: random images against a byte-level pixel
// model, plus result encoding, ignored strobes and reset behaviour.
module tb_snn_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [9:0] core_addr = 10'h000;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = 4'h0;
   logic       tx_done = 1'b0;
   logic       ram_we;
   logic [9:0] ram_addr;
   logic       ram_d;
   logic       core_start;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [3:0] digit_out;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [9:0] obs_addr[$];
   logic       obs_d[$];
   logic [9:0] exp_addr[$];
   logic       exp_d[$];
   int         model_pix = 0;
   int         cyc = 0;
   int         last_we_cyc = -1;
   int         start_cyc = -1;
   int         start_pulses = 0;
   int         tx_pulses = 0;

   snn_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_d      (ram_d),
      .core_addr  (core_addr),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .digit_out  (digit_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Passive monitor: records every RAM write and pulse, mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (ram_we === 1'b1) begin
         obs_addr.push_back(ram_addr);
         obs_d.push_back(ram_d);
         last_we_cyc = cyc;
      end
      if (core_start === 1'b1) begin
         start_pulses++;
         start_cyc = cyc;
      end
      if (tx_start === 1'b1) begin
         tx_pulses++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Model: byte n of an image fills pixels 8n..8n+7, LSB first.
   function automatic void model_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(10'(model_pix + i));
         exp_d.push_back(b[i]);
      end
      model_pix += 8;
      if (model_pix == 784) begin
         model_pix = 0;
      end
   endfunction

   function automatic logic [7:0] model_ascii(input logic [3:0] d);
      int v;
      v = d;
      if (v <= 9) begin
         return 8'(48 + v);
      end
      return 8'd63;
   endfunction

   function automatic int write_diffs();
      int n;
      n = 0;
      if (obs_addr.size() != exp_addr.size()) begin
         n++;
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         if (obs_addr[i] !== exp_addr[i] || obs_d[i] !== exp_d[i]) begin
            n++;
         end
      end
      obs_addr.delete();
      obs_d.delete();
      exp_addr.delete();
      exp_d.delete();
      return n;
   endfunction

   task automatic clear_history();
      obs_addr.delete();
      obs_d.delete();
      exp_addr.delete();
      exp_d.delete();
      model_pix = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_history();
      step();
   endtask

   // Sends one byte from LOAD; optional stray rx_rdy during WRITE cycle 'glitch'.
   task automatic send_byte(input logic [7:0] b, input int glitch);
      rx_data = b;
      rx_rdy  = 1'b1;
      step();
      rx_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == glitch) begin
            rx_rdy  = 1'b1;
            rx_data = ~b;
         end
         step();
         rx_rdy = 1'b0;
      end
      model_byte(b);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({ram_we, ram_d, core_start, tx_start, busy, tx_data, digit_out} !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h, want 0000",
                  {ram_we, ram_d, core_start, tx_start, busy, tx_data, digit_out});
      end
      checks++;
      if (ram_addr !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_ram_addr: got %h, want 000", ram_addr);
      end
      step();
      rst_n = 1'b1;
      clear_history();
      step();
      step();
      checks++;
      if (busy !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_load: got busy=%b we=%b, want 0 0", busy, ram_we);
      end
   endtask

   task automatic test_single_byte();
      int nobs;
      int nexp;
      int d;
      do_reset();
      send_byte(8'hA5, -1);
      nobs = obs_addr.size();
      nexp = exp_addr.size();
      d = write_diffs();
      checks++;
      if (d !== 0) begin
         errors++;
         $display("[TB] FAIL a5_writes: %0d bad (saw %0d writes, want %0d)", d, nobs, nexp);
      end
      checks++;
      if (busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd8) begin
         errors++;
         $display("[TB] FAIL a5_back_to_load: got busy=%b we=%b addr=%0d, want 0 0 8",
                  busy, ram_we, ram_addr);
      end
   endtask

   // Sends a full 98-byte image and checks the handoff to the core.
   task automatic test_image(input bit use_ff, input int glitch_every);
      logic [7:0] b;
      int glitch;
      int nobs;
      int nexp;
      int d;
      int busy_bad;
      busy_bad = 0;
      start_pulses = 0;
      for (int n = 0; n < 98; n++) begin
         b = use_ff ? 8'hFF : 8'($urandom);
         glitch = -1;
         if (glitch_every > 0 && (n % glitch_every) == 0) begin
            glitch = $urandom_range(0, 7);
         end
         send_byte(b, glitch);
         if (n < 97 && busy !== 1'b0) begin
            busy_bad++;
         end
      end
      checks++;
      if (busy_bad !== 0) begin
         errors++;
         $display("[TB] FAIL image_busy_between_bytes: got %0d busy bytes, want 0", busy_bad);
      end
      nobs = obs_addr.size();
      nexp = exp_addr.size();
      d = write_diffs();
      checks++;
      if (d !== 0) begin
         errors++;
         $display("[TB] FAIL image_writes: %0d bad (saw %0d writes, want %0d)", d, nobs, nexp);
      end
      checks++;
      if (core_start !== 1'b1 || busy !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL image_start: got start=%b busy=%b we=%b, want 1 1 0",
                  core_start, busy, ram_we);
      end
      checks++;
      if (start_cyc !== last_we_cyc + 1) begin
         errors++;
         $display("[TB] FAIL start_latency: got %0d cycles, want 1", start_cyc - last_we_cyc);
      end
      step();
      checks++;
      if (core_start !== 1'b0 || start_pulses !== 1) begin
         errors++;
         $display("[TB] FAIL start_single_pulse: got start=%b pulses=%0d, want 0 1",
                  core_start, start_pulses);
      end
   endtask

   // Runs WAIT -> TX -> TX_WAIT -> LOAD with a given digit.
   task automatic test_wait_tx(input logic [3:0] digit, input logic [9:0] caddr, input bit glitch);
      logic [7:0] want;
      logic [3:0] other;
      want  = model_ascii(digit);
      other = digit + 4'd3;
      tx_pulses = 0;
      core_addr = caddr;
      #1;
      checks++;
      if (ram_addr !== caddr || ram_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_addr_mux: got addr=%h we=%b, want %h 0", ram_addr, ram_we, caddr);
      end
      for (int i = 0; i < 6; i++) begin
         if (glitch && i == 1) begin
            rx_rdy  = 1'b1;
            rx_data = 8'($urandom);
         end
         if (glitch && i == 3) begin
            tx_done = 1'b1;
         end
         step();
         rx_rdy  = 1'b0;
         tx_done = 1'b0;
      end
      checks++;
      if (obs_addr.size() !== 0 || busy !== 1'b1 || tx_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_holds: got writes=%0d busy=%b tx_start=%b, want 0 1 0",
                  obs_addr.size(), busy, tx_start);
      end
      core_digit = digit;
      core_done  = 1'b1;
      step();
      core_done  = 1'b0;
      core_digit = other;
      checks++;
      if (digit_out !== digit || tx_start !== 1'b1 || tx_data !== want) begin
         errors++;
         $display("[TB] FAIL tx_result: got digit=%h start=%b data=%h, want %h 1 %h",
                  digit_out, tx_start, tx_data, digit, want);
      end
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      step();
      checks++;
      if (tx_start !== 1'b0 || tx_data !== want || digit_out !== digit || tx_pulses !== 1) begin
         errors++;
         $display("[TB] FAIL tx_wait_hold: got start=%b data=%h digit=%h pulses=%0d, want 0 %h %h 1",
                  tx_start, tx_data, digit_out, tx_pulses, want, digit);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      checks++;
      if (busy !== 1'b0 || ram_addr !== 10'd0 || tx_data !== want) begin
         errors++;
         $display("[TB] FAIL tx_done_to_load: got busy=%b addr=%h data=%h, want 0 000 %h",
                  busy, ram_addr, tx_data, want);
      end
   endtask

   task automatic test_back_to_back();
      test_image(1'b0, 7);
      test_wait_tx(4'hC, 10'($urandom), 1'b1);
      test_image(1'b0, 0);
      test_wait_tx(4'($urandom_range(0, 15)), 10'($urandom), 1'b0);
   endtask

   task automatic test_reset_mid_image();
      int nobs;
      int nexp;
      int d;
      for (int n = 0; n < 50; n++) begin
         send_byte(8'($urandom), -1);
      end
      nobs = obs_addr.size();
      nexp = exp_addr.size();
      d = write_diffs();
      checks++;
      if (d !== 0) begin
         errors++;
         $display("[TB] FAIL partial_writes: %0d bad (saw %0d writes, want %0d)", d, nobs, nexp);
      end
      rx_data = 8'hFF;
      rx_rdy  = 1'b1;
      step();
      rx_rdy = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ram_we, ram_d, core_start, tx_start, busy, tx_data, digit_out} !== 16'h0000
          || ram_addr !== 10'd0) begin
         errors++;
         $display("[TB] FAIL midwrite_reset: got %h addr=%h, want 0000 000",
                  {ram_we, ram_d, core_start, tx_start, busy, tx_data, digit_out}, ram_addr);
      end
      step();
      rst_n = 1'b1;
      clear_history();
      step();
      test_image(1'b0, 0);
      test_wait_tx(4'd9, 10'h2AA, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      do_reset();
      test_image(1'b1, 0);
      test_wait_tx(4'd7, 10'h155, 1'b1);
      test_back_to_back();
      test_reset_mid_image();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snn_ctrl.md
SNN_CTRL -- requirements
Module: snn_ctrl

Interface
REQ-001 clk  input  1  system clock, all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 rx_rdy  input  1  one-cycle pulse, new image byte on rx_data.
REQ-004 rx_data  input  8  image byte, 8 pixels, LSB = lowest pixel index.
REQ-005 ram_we  output  1  write enable to the 784x1 input-unit RAM.
REQ-006 ram_addr  output  10  input-unit RAM address.
REQ-007 ram_d  output  1  pixel bit written to the input-unit RAM.
REQ-008 core_addr  input  10  read address driven by the inference core.
REQ-009 core_start  output  1  one-cycle start pulse to the inference core.
REQ-010 core_done  input  1  one-cycle completion pulse from the inference core.
REQ-011 core_digit  input  4  classified digit, valid in the core_done cycle.
REQ-012 tx_start  output  1  one-cycle pulse, send tx_data to the serial transmitter.
REQ-013 tx_data  output  8  ASCII result byte.
REQ-014 tx_done  input  1  one-cycle pulse, transmitter finished.
REQ-015 digit_out  output  4  last classified digit, held until the next result.
REQ-016 busy  output  1  high in every state except LOAD.

Function
REQ-017 States LOAD, WRITE, START, WAIT, TX, TX_WAIT; reset state LOAD.
REQ-018 LOAD: on rx_rdy, latch rx_data into an 8-bit shift register and go to WRITE; otherwise stay.
REQ-019 WRITE lasts exactly 8 cycles: ram_we=1, ram_d=shift[0], ram_addr=pixel counter; shift right and increment the counter each cycle.
REQ-020 Pixel counter is 10 bits, runs 0..783, and is cleared on entry to START.
REQ-021 After the 8th WRITE cycle: if the counter wrote address 783 (98th byte), go to START; else return to LOAD.
REQ-022 rx_rdy outside LOAD is ignored; the byte is dropped and no state changes.
REQ-023 ram_addr = pixel counter in LOAD/WRITE; ram_addr = core_addr in START/WAIT/TX/TX_WAIT (combinational mux).
REQ-024 ram_we is 0 in every state except WRITE.
REQ-025 START: core_start=1 for exactly one cycle, then go to WAIT.
REQ-026 WAIT: on core_done, register core_digit into digit_out and go to TX; otherwise stay, with no timeout.
REQ-027 TX: tx_start=1 for one cycle; tx_data = 8'h30 + digit_out when digit_out <= 9, else 8'h3F; go to TX_WAIT.
REQ-028 tx_data holds its value through TX_WAIT.
REQ-029 TX_WAIT: on tx_done, go to LOAD, ready for the next image; otherwise stay.
REQ-030 core_done outside WAIT and tx_done outside TX_WAIT are ignored.
REQ-031 Latency: start pulse one cycle after the final WRITE cycle; tx_start one cycle after the core_done cycle.

Reset
REQ-032 rst_n low forces LOAD and clears the pixel counter, shift register, digit_out, tx_data, ram_we, ram_d, core_start, tx_start and busy to 0, from any state.
REQ-033 Reset mid-image discards partial data; the next rx_rdy after release is treated as byte 0 (addresses 0..7).

Verification
REQ-034 Reset release, rx_rdy with rx_data=8'hA5 -> 8 WRITE cycles at addresses 0..7 with ram_d 1,0,1,0,0,1,0,1; then LOAD, busy=0.
REQ-035 98 bytes of 8'hFF -> 784 writes, last at address 783; core_start pulses once, one cycle after the last write; busy=1.
REQ-036 In WAIT, drive core_addr=10'h155 -> ram_addr=10'h155 and ram_we=0; core_done with core_digit=7 -> digit_out=7; next cycle tx_start=1 with tx_data=8'h37.
REQ-037 core_digit=4'hC -> tx_data=8'h3F; tx_done -> LOAD; the next image is written starting at address 0.
REQ-038 rx_rdy pulsed during WRITE and WAIT, and tx_done pulsed in WAIT -> no extra writes, no address skip, no state change.
REQ-039 rst_n asserted in WRITE after 50 bytes -> all outputs 0 immediately; after release, a full 98-byte image completes normally.
